// File: rtl/axi_slv_pkg.sv
// Shared encodings for the AXI3 slave endpoint.
//  - AXI response and burst-type codes
//  - write / read FSM state encodings
//  - small helper that turns a sticky burst error into a BRESP code
package axi_slv_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic [1:0] wr_resp(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/slv_sync_fifo.sv
// Single-clock show-ahead FIFO.
//  push/wdata : write side, ignored while full
//  pop        : read side, ignored while empty; rdata always shows the head
//  full/empty : derived from AW+1-bit pointers (the extra MSB tells a
//               wrapped-full pointer pair apart from an empty one)
// Reset (asynchronous, active-high) empties the FIFO; storage is not cleared.
module slv_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             push_ok, pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // full blocks a push even if a pop happens in the same cycle
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi_slave_fifo.sv
// AXI3 slave endpoint between the interconnect/NIC and a local core.
//  AW/W/B : write bursts are buffered beat by beat ({WSTRB,WDATA}) in a write
//           FIFO the core drains (CORE_WDATA/WSTRB/WVALID, CORE_WDEQ); one B
//           response per burst, SLVERR if any beat had a WLAST or WID mismatch.
//  AR/R   : read bursts stream words the core pushes into a read FIFO
//           (CORE_RDATA/CORE_RWE, CORE_RFULL) back as R beats with RLAST.
//  CORE_WREQ/CORE_RREQ : one-cycle pulse on address accept; address/length
//           outputs hold the burst info until the next accept.
// ACLK rising edge; ARESETn asynchronous, active-high, aborts any burst and
// flushes both FIFOs. Size/burst fields are ignored: the core steps addresses.
module axi_slave_fifo
  import axi_slv_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 32,
  parameter int ID_WIDTH = 4,
  parameter int FIFO_AW  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address
  input  logic [ID_WIDTH-1:0] AWID,
  input  logic [AWIDTH-1:0]   AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data
  input  logic [ID_WIDTH-1:0] WID,
  input  logic [DWIDTH-1:0]   WDATA,
  input  logic [DWIDTH/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response
  output logic [ID_WIDTH-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address
  input  logic [ID_WIDTH-1:0] ARID,
  input  logic [AWIDTH-1:0]   ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data
  output logic [ID_WIDTH-1:0] RID,
  output logic [DWIDTH-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  // core write side
  output logic                CORE_WREQ,
  output logic [AWIDTH-1:0]   CORE_WADDR,
  output logic [3:0]          CORE_WLEN,
  output logic [DWIDTH-1:0]   CORE_WDATA,
  output logic [DWIDTH/8-1:0] CORE_WSTRB,
  output logic                CORE_WVALID,
  input  logic                CORE_WDEQ,
  // core read side
  output logic                CORE_RREQ,
  output logic [AWIDTH-1:0]   CORE_RADDR,
  output logic [3:0]          CORE_RLEN,
  input  logic [DWIDTH-1:0]   CORE_RDATA,
  input  logic                CORE_RWE,
  output logic                CORE_RFULL
);

  localparam int SW  = DWIDTH / 8;
  localparam int WFW = DWIDTH + SW;

  // size/burst fields carry no meaning for this endpoint
  logic unused_fields;
  assign unused_fields = &{1'b0, AWSIZE, AWBURST, ARSIZE, ARBURST};

  // ---------------------------------------------------------------- write path
  wr_state_e           wstate;
  logic [3:0]          aw_len, wcnt;
  logic                werr;
  logic                wf_full, wf_empty;
  logic [WFW-1:0]      wf_rdata;
  logic                w_hs, w_last_beat, w_beat_err;

  // WREADY looks only at state and FIFO fullness, never at WVALID
  assign WREADY      = (wstate == W_DATA) & ~wf_full;
  assign w_hs        = WVALID & WREADY;
  // the beat count, not WLAST, decides where the burst ends
  assign w_last_beat = (wcnt == aw_len);
  assign w_beat_err  = (WLAST != w_last_beat) | (WID != BID);

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      wstate     <= W_IDLE;
      AWREADY    <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= AXI_RESP_OKAY;
      BID        <= '0;
      CORE_WREQ  <= 1'b0;
      CORE_WADDR <= '0;
      CORE_WLEN  <= '0;
      aw_len     <= '0;
      wcnt       <= '0;
      werr       <= 1'b0;
    end else begin
      CORE_WREQ <= 1'b0;
      case (wstate)
        W_IDLE: begin
          if (AWREADY && AWVALID) begin
            // BID doubles as the latched AWID for the WID check
            BID        <= AWID;
            aw_len     <= AWLEN;
            CORE_WADDR <= AWADDR;
            CORE_WLEN  <= AWLEN;
            CORE_WREQ  <= 1'b1;
            wcnt       <= '0;
            werr       <= 1'b0;
            AWREADY    <= 1'b0;
            wstate     <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wcnt <= wcnt + 1'b1;
            werr <= werr | w_beat_err;
            if (w_last_beat) begin
              BVALID <= 1'b1;
              BRESP  <= wr_resp(werr | w_beat_err);
              wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            wstate  <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  slv_sync_fifo #(.WIDTH(WFW), .AW(FIFO_AW)) u_wfifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (w_hs),
    .wdata   ({WSTRB, WDATA}),
    .pop     (CORE_WDEQ),
    .rdata   (wf_rdata),
    .full    (wf_full),
    .empty   (wf_empty)
  );

  assign CORE_WDATA  = wf_rdata[DWIDTH-1:0];
  assign CORE_WSTRB  = wf_rdata[DWIDTH +: SW];
  assign CORE_WVALID = ~wf_empty;

  // ----------------------------------------------------------------- read path
  rd_state_e           rstate;
  logic [3:0]          ar_len, rcnt;
  logic                rf_full, rf_empty;
  logic                r_hs, r_last_beat;

  // data sitting in the FIFO while idle waits for the next AR
  assign RVALID      = (rstate == R_DATA) & ~rf_empty;
  assign r_last_beat = (rcnt == ar_len);
  assign RLAST       = RVALID & r_last_beat;
  assign RRESP       = AXI_RESP_OKAY;
  assign r_hs        = RVALID & RREADY;
  assign CORE_RFULL  = rf_full;

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      rstate     <= R_IDLE;
      ARREADY    <= 1'b0;
      RID        <= '0;
      CORE_RREQ  <= 1'b0;
      CORE_RADDR <= '0;
      CORE_RLEN  <= '0;
      ar_len     <= '0;
      rcnt       <= '0;
    end else begin
      CORE_RREQ <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (ARREADY && ARVALID) begin
            RID        <= ARID;
            ar_len     <= ARLEN;
            CORE_RADDR <= ARADDR;
            CORE_RLEN  <= ARLEN;
            CORE_RREQ  <= 1'b1;
            rcnt       <= '0;
            ARREADY    <= 1'b0;
            rstate     <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            rcnt <= rcnt + 1'b1;
            if (r_last_beat) begin
              ARREADY <= 1'b1;
              rstate  <= R_IDLE;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  slv_sync_fifo #(.WIDTH(DWIDTH), .AW(FIFO_AW)) u_rfifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (CORE_RWE),
    .wdata   (CORE_RDATA),
    .pop     (r_hs),
    .rdata   (RDATA),
    .full    (rf_full),
    .empty   (rf_empty)
  );

endmodule

// File: tb/tb_axi_slave_fifo.sv
module tb_axi_slave_fifo;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [3:0]  AWID = '0, WID = '0, ARID = '0;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0, CORE_RDATA = '0;
  logic [3:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0;
  logic [2:0]  AWSIZE = 3'd2, ARSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'b01, ARBURST = 2'b01;
  logic        AWVALID = 0, WLAST = 0, WVALID = 0, BREADY = 1, ARVALID = 0, RREADY = 0;
  logic        CORE_WDEQ = 0, CORE_RWE = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [3:0]  BID, RID, CORE_WLEN, CORE_RLEN, CORE_WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA, CORE_WADDR, CORE_RADDR, CORE_WDATA;
  logic        CORE_WREQ, CORE_WVALID, CORE_RREQ, CORE_RFULL;

  axi_slave_fifo dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CORE_WREQ(CORE_WREQ), .CORE_WADDR(CORE_WADDR), .CORE_WLEN(CORE_WLEN),
    .CORE_WDATA(CORE_WDATA), .CORE_WSTRB(CORE_WSTRB), .CORE_WVALID(CORE_WVALID),
    .CORE_WDEQ(CORE_WDEQ),
    .CORE_RREQ(CORE_RREQ), .CORE_RADDR(CORE_RADDR), .CORE_RLEN(CORE_RLEN),
    .CORE_RDATA(CORE_RDATA), .CORE_RWE(CORE_RWE), .CORE_RFULL(CORE_RFULL)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  // expected-response queues
  logic [5:0]  bq[$];     // {bid, bresp}
  logic [35:0] wq[$];     // {strb, data} in core pop order
  logic [36:0] rq[$];     // {rid, rdata, rlast}
  logic [35:0] wreqq[$];  // {addr, len}
  logic [35:0] rreqq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // ---------------------------------------------------------------- monitors
  logic [5:0]  be;
  logic [35:0] we, wre, rre;
  logic [36:0] re;

  always @(negedge ACLK) if (!ARESETn) begin
    if (BVALID && BREADY) begin
      if (bq.size() == 0) flag("b_unexpected");
      else begin
        be = bq.pop_front();
        chk("bid", 64'(BID), 64'(be[5:2]));
        chk("bresp", 64'(BRESP), 64'(be[1:0]));
      end
    end
  end

  always @(negedge ACLK) if (!ARESETn) begin
    if (CORE_WVALID && CORE_WDEQ) begin
      if (wq.size() == 0) flag("core_w_unexpected");
      else begin
        we = wq.pop_front();
        chk("core_wdata", 64'(CORE_WDATA), 64'(we[31:0]));
        chk("core_wstrb", 64'(CORE_WSTRB), 64'(we[35:32]));
      end
    end
  end

  always @(negedge ACLK) if (!ARESETn) begin
    if (RVALID && RREADY) begin
      if (rq.size() == 0) flag("r_unexpected");
      else begin
        re = rq.pop_front();
        chk("rid", 64'(RID), 64'(re[36:33]));
        chk("rdata", 64'(RDATA), 64'(re[32:1]));
        chk("rlast", 64'(RLAST), 64'(re[0]));
        chk("rresp", 64'(RRESP), 64'd0);
      end
    end
  end

  always @(negedge ACLK) if (!ARESETn) begin
    if (CORE_WREQ) begin
      if (wreqq.size() == 0) flag("core_wreq_unexpected");
      else begin
        wre = wreqq.pop_front();
        chk("core_waddr", 64'(CORE_WADDR), 64'(wre[35:4]));
        chk("core_wlen", 64'(CORE_WLEN), 64'(wre[3:0]));
      end
    end
    if (CORE_RREQ) begin
      if (rreqq.size() == 0) flag("core_rreq_unexpected");
      else begin
        rre = rreqq.pop_front();
        chk("core_raddr", 64'(CORE_RADDR), 64'(rre[35:4]));
        chk("core_rlen", 64'(CORE_RLEN), 64'(rre[3:0]));
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) flag("aw_timeout");
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n;
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) flag("ar_timeout");
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] id, input logic [31:0] d, input logic [3:0] s,
                        input logic last);
    int n;
    WID = id; WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!WREADY) flag("w_timeout");
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic push_r(input logic [31:0] d);
    CORE_RDATA = d; CORE_RWE = 1'b1;
    tick();
    CORE_RWE = 1'b0;
  endtask

  task automatic pop_w(input int n);
    CORE_WDEQ = 1'b1;
    repeat (n) tick();
    CORE_WDEQ = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge ACLK);
    while ((bq.size() + wq.size() + rq.size() + wreqq.size() + rreqq.size()) != 0 && n < 200) begin
      @(negedge ACLK); n++;
    end
    if ((bq.size() + wq.size() + rq.size() + wreqq.size() + rreqq.size()) != 0) flag(name);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 ARESETn = 1'b1;
    tick(); tick();
    // reset state
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_bresp", 64'(BRESP), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_rlast", 64'(RLAST), 64'd0);
    chk("rst_wreq", 64'(CORE_WREQ), 64'd0);
    chk("rst_rreq", 64'(CORE_RREQ), 64'd0);
    chk("rst_core_wvalid", 64'(CORE_WVALID), 64'd0);
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("rel_awready_before_edge", 64'(AWREADY), 64'd0);
    tick();
    chk("rel_awready", 64'(AWREADY), 64'd1);
    chk("rel_arready", 64'(ARREADY), 64'd1);

    // 1: 4-beat write, correct WLAST -> OKAY
    bq.push_back({4'd3, 2'b00});
    wreqq.push_back({32'h100, 4'd3});
    send_aw(4'd3, 32'h100, 4'd3);
    for (int i = 0; i < 4; i++) begin
      wq.push_back({4'hF, 32'hA0 + 32'(i)});
      send_w(4'd3, 32'hA0 + 32'(i), 4'hF, i == 3);
    end
    @(negedge ACLK);
    chk("t1_core_wvalid", 64'(CORE_WVALID), 64'd1);
    tick();
    pop_w(4);
    wait_idle("t1_drain_timeout");
    chk("t1_core_wvalid_empty", 64'(CORE_WVALID), 64'd0);

    // 2: WLAST on beat 2 -> all 4 beats kept, SLVERR
    bq.push_back({4'd3, 2'b10});
    wreqq.push_back({32'h100, 4'd3});
    send_aw(4'd3, 32'h100, 4'd3);
    for (int i = 0; i < 4; i++) begin
      wq.push_back({4'hF, 32'hA0 + 32'(i)});
      send_w(4'd3, 32'hA0 + 32'(i), 4'hF, i == 1);
    end
    pop_w(4);
    wait_idle("t2_drain_timeout");

    // 3: fill the write FIFO (16 beats, no pops), 17th beat stalls until one pop
    bq.push_back({4'd1, 2'b00});
    wreqq.push_back({32'h400, 4'd15});
    send_aw(4'd1, 32'h400, 4'd15);
    for (int i = 0; i < 16; i++) begin
      wq.push_back({4'(i), 32'h300 + 32'(i)});
      send_w(4'd1, 32'h300 + 32'(i), 4'(i), i == 15);
    end
    bq.push_back({4'd2, 2'b00});
    wreqq.push_back({32'h500, 4'd0});
    send_aw(4'd2, 32'h500, 4'd0);
    wq.push_back({4'h5, 32'h3FF});
    WID = 4'd2; WDATA = 32'h3FF; WSTRB = 4'h5; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("t3_wready_full", 64'(WREADY), 64'd0);
    tick();
    @(negedge ACLK);
    chk("t3_wready_full2", 64'(WREADY), 64'd0);
    tick();
    CORE_WDEQ = 1'b1;
    tick();
    CORE_WDEQ = 1'b0;
    @(negedge ACLK);
    chk("t3_wready_resume", 64'(WREADY), 64'd1);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    pop_w(16);
    wait_idle("t3_drain_timeout");

    // 4: 8-beat read, RREADY toggling every cycle
    rreqq.push_back({32'h200, 4'd7});
    for (int i = 0; i < 8; i++) rq.push_back({4'd5, 32'hB0 + 32'(i), i == 7});
    send_ar(4'd5, 32'h200, 4'd7);
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          tick();
          RREADY = ~RREADY;
        end
      end
      begin
        for (int j = 0; j < 8; j++) push_r(32'hB0 + 32'(j));
      end
    join
    RREADY = 1'b0;
    wait_idle("t4_drain_timeout");

    // 5: AR with empty read FIFO; RVALID waits for the first core push
    rreqq.push_back({32'h280, 4'd1});
    rq.push_back({4'd6, 32'hC0, 1'b0});
    rq.push_back({4'd6, 32'hC1, 1'b1});
    send_ar(4'd6, 32'h280, 4'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("t5_rvalid_empty", 64'(RVALID), 64'd0);
      tick();
    end
    CORE_RDATA = 32'hC0; CORE_RWE = 1'b1;
    @(negedge ACLK);
    chk("t5_rvalid_same_cycle", 64'(RVALID), 64'd0);
    tick();
    CORE_RWE = 1'b0;
    @(negedge ACLK);
    chk("t5_rvalid_after_push", 64'(RVALID), 64'd1);
    chk("t5_rdata", 64'(RDATA), 64'hC0);
    tick();
    @(negedge ACLK);
    chk("t5_rdata_stable", 64'(RDATA), 64'hC0);
    chk("t5_rlast_first", 64'(RLAST), 64'd0);
    tick();
    RREADY = 1'b1;
    push_r(32'hC1);
    wait_idle("t5_drain_timeout");
    RREADY = 1'b0;

    // 6: reset during beat 2 of a 4-beat write -> no B, FIFO flushed
    wreqq.push_back({32'h600, 4'd3});
    send_aw(4'd2, 32'h600, 4'd3);
    send_w(4'd2, 32'hE0, 4'hF, 1'b0);
    send_w(4'd2, 32'hE1, 4'hF, 1'b0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("t6_bvalid", 64'(BVALID), 64'd0);
    chk("t6_core_wvalid", 64'(CORE_WVALID), 64'd0);
    chk("t6_awready_in_rst", 64'(AWREADY), 64'd0);
    tick();
    ARESETn = 1'b0;
    @(negedge ACLK);
    chk("t6_awready_before_edge", 64'(AWREADY), 64'd0);
    tick();
    chk("t6_awready_after", 64'(AWREADY), 64'd1);
    chk("t6_core_wvalid_after", 64'(CORE_WVALID), 64'd0);
    repeat (5) tick();
    chk("t6_no_bvalid", 64'(BVALID), 64'd0);
    // endpoint still works after the abort
    bq.push_back({4'd7, 2'b00});
    wreqq.push_back({32'h700, 4'd0});
    wq.push_back({4'h3, 32'hD0});
    send_aw(4'd7, 32'h700, 4'd0);
    send_w(4'd7, 32'hD0, 4'h3, 1'b1);
    pop_w(1);
    wait_idle("t6_drain_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
